// File: rtl/cam_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// cam_pkg: shared pattern codes, bar colours and default timing
// Rev 1.0
// ------------------------------------------------------------------
package cam_pkg;

  localparam logic [1:0] PAT_SOLID = 2'd0;
  localparam logic [1:0] PAT_BARS  = 2'd1;
  localparam logic [1:0] PAT_GRAD  = 2'd2;
  localparam logic [1:0] PAT_COUNT = 2'd3;

  localparam int DEF_H_PIX   = 160;
  localparam int DEF_V_LINES = 120;
  localparam int DEF_VS_LEN  = 8;
  localparam int DEF_VFP     = 10;
  localparam int DEF_HBLANK  = 16;
  localparam int DEF_VBP     = 10;

  // Entry 0 is the leftmost bar.
  localparam logic [7:0][11:0] BAR_COLORS = {
    12'h000, 12'h00F, 12'hF00, 12'hF0F,
    12'h0F0, 12'h0FF, 12'hFF0, 12'hFFF
  };

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_VS   = 3'd1,
    S_FP   = 3'd2,
    S_LINE = 3'd3,
    S_HB   = 3'd4,
    S_BP   = 3'd5
  } cam_state_t;

endpackage
`default_nettype wire

// File: rtl/cam_pattern_pixel.sv
`default_nettype none
// ------------------------------------------------------------------
// cam_pattern_pixel: combinational (pattern, x, y) -> RGB444 mapping
// Rev 1.0
// ------------------------------------------------------------------
module cam_pattern_pixel
  import cam_pkg::*;
#(
  parameter int H_PIX = DEF_H_PIX,
  parameter int X_W   = 8,
  parameter int Y_W   = 7
) (
  input  logic [1:0]     pattern,
  input  logic [X_W-1:0] x,
  input  logic [Y_W-1:0] y,
  input  logic [3:0]     frame_cnt,   // low nibble of the frame counter
  input  logic [11:0]    solid_color,
  output logic [11:0]    rgb
);

  localparam int BAR_W = (H_PIX >= 8) ? (H_PIX / 8) : 1;

  int         bar_i;
  logic [2:0] bar_idx;
  logic [11:0] linear;

  always_comb begin
    bar_i   = int'(x) / BAR_W;
    // Leftover pixels when H_PIX is not a multiple of 8 stay in the last bar.
    bar_idx = (bar_i > 7) ? 3'd7 : bar_i[2:0];
    linear  = 12'(y) * 12'(H_PIX) + 12'(x);
  end

  always_comb begin
    rgb = solid_color;
    case (pattern)
      PAT_SOLID: rgb = solid_color;
      PAT_BARS:  rgb = BAR_COLORS[bar_idx];
      PAT_GRAD:  rgb = {4'(x), 4'(y), frame_cnt};
      PAT_COUNT: rgb = linear;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/cam_pattern_gen.sv
`default_nettype none
// ------------------------------------------------------------------
// cam_pattern_gen: camera-style VSYNC/HREF/byte stream test source
// Rev 1.0
// ------------------------------------------------------------------
module cam_pattern_gen
  import cam_pkg::*;
#(
  parameter int H_PIX   = DEF_H_PIX,
  parameter int V_LINES = DEF_V_LINES,
  parameter int VS_LEN  = DEF_VS_LEN,
  parameter int VFP     = DEF_VFP,
  parameter int HBLANK  = DEF_HBLANK,
  parameter int VBP     = DEF_VBP
) (
  input  logic        CAM_PCLK,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [11:0] solid_color,
  output logic        CAM_VSYNC,
  output logic        CAM_HREF,
  output logic [7:0]  CAM_px_data,
  output logic        frame_done
);

  localparam int LINE_CYC = 2 * H_PIX;
  localparam int MAX1     = (LINE_CYC > VS_LEN) ? LINE_CYC : VS_LEN;
  localparam int MAX2     = (MAX1 > VFP) ? MAX1 : VFP;
  localparam int MAX3     = (MAX2 > HBLANK) ? MAX2 : HBLANK;
  localparam int CNT_MAX  = (MAX3 > VBP) ? MAX3 : VBP;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam int X_W      = $clog2(H_PIX + 1);
  localparam int Y_W      = $clog2(V_LINES + 1);

  localparam logic [CNT_W-1:0] VS_LAST   = CNT_W'(VS_LEN - 1);
  localparam logic [CNT_W-1:0] FP_LAST   = CNT_W'(VFP - 1);
  localparam logic [CNT_W-1:0] LINE_LAST = CNT_W'(LINE_CYC - 1);
  localparam logic [CNT_W-1:0] HB_LAST   = CNT_W'(HBLANK - 1);
  localparam logic [CNT_W-1:0] BP_LAST   = CNT_W'(VBP - 1);
  localparam logic [Y_W-1:0]   LAST_LINE = Y_W'(V_LINES - 1);

  cam_state_t       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, last_cnt;
  logic [Y_W-1:0]   line, line_n;
  logic [7:0]       frame_cnt;
  logic [1:0]       pat;
  logic [11:0]      color;
  logic             at_end, latch, done;
  logic [X_W-1:0]   px_x;
  logic [11:0]      rgb;

  always_ff @(posedge CAM_PCLK) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      line      <= '0;
      frame_cnt <= '0;
      pat       <= PAT_SOLID;
      color     <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      line  <= line_n;
      if (done) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
      // Pattern and colour are frozen at each frame start.
      if (latch) begin
        pat   <= pattern_sel;
        color <= solid_color;
      end
    end
  end

  always_comb begin
    case (state)
      S_VS:    last_cnt = VS_LAST;
      S_FP:    last_cnt = FP_LAST;
      S_LINE:  last_cnt = LINE_LAST;
      S_HB:    last_cnt = HB_LAST;
      S_BP:    last_cnt = BP_LAST;
      default: last_cnt = '0;
    endcase
  end

  assign at_end = (cnt == last_cnt);

  always_comb begin
    state_n = state;
    cnt_n   = cnt + CNT_W'(1);
    line_n  = line;
    latch   = 1'b0;
    done    = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_n  = '0;
        line_n = '0;
        if (enable) begin
          state_n = S_VS;
          latch   = 1'b1;
        end
      end
      S_VS: begin
        if (at_end) begin
          state_n = S_FP;
          cnt_n   = '0;
        end
      end
      S_FP: begin
        if (at_end) begin
          state_n = S_LINE;
          cnt_n   = '0;
          line_n  = '0;
        end
      end
      S_LINE: begin
        if (at_end) begin
          cnt_n   = '0;
          state_n = (line == LAST_LINE) ? S_BP : S_HB;
        end
      end
      S_HB: begin
        if (at_end) begin
          state_n = S_LINE;
          cnt_n   = '0;
          line_n  = line + Y_W'(1);
        end
      end
      S_BP: begin
        if (at_end) begin
          done   = 1'b1;
          cnt_n  = '0;
          line_n = '0;
          // enable is only consulted here, so a frame is never cut short.
          if (enable) begin
            state_n = S_VS;
            latch   = 1'b1;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
        line_n  = '0;
      end
    endcase
  end

  assign px_x = X_W'(cnt >> 1);

  cam_pattern_pixel #(
    .H_PIX (H_PIX),
    .X_W   (X_W),
    .Y_W   (Y_W)
  ) u_pixel (
    .pattern     (pat),
    .x           (px_x),
    .y           (line),
    .frame_cnt   (frame_cnt[3:0]),
    .solid_color (color),
    .rgb         (rgb)
  );

  assign CAM_VSYNC   = (state == S_VS);
  assign CAM_HREF    = (state == S_LINE);
  assign frame_done  = done;
  assign CAM_px_data = !CAM_HREF ? 8'h00 :
                       (cnt[0] ? rgb[7:0] : {4'h0, rgb[11:8]});

endmodule
`default_nettype wire

// File: tb/tb_cam_pattern_gen.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_cam_pattern_gen: directed bench for the camera pattern source
// Rev 1.0
// ------------------------------------------------------------------
module tb_cam_pattern_gen;

  localparam int NL        = 120;
  localparam int NB        = 320;
  localparam int FRAME_LEN = 40332;
  localparam int WAIT_MAX  = 41000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [11:0] solid_color = 12'h000;
  logic        CAM_VSYNC;
  logic        CAM_HREF;
  logic [7:0]  CAM_px_data;
  logic        frame_done;

  always #5 clk = ~clk;

  cam_pattern_gen dut (
    .CAM_PCLK    (clk),
    .rst         (rst),
    .enable      (enable),
    .pattern_sel (pattern_sel),
    .solid_color (solid_color),
    .CAM_VSYNC   (CAM_VSYNC),
    .CAM_HREF    (CAM_HREF),
    .CAM_px_data (CAM_px_data),
    .frame_done  (frame_done)
  );

  typedef struct {
    int         frame;
    int         x;
    int         y;
    logic [7:0] b0;
    logic [7:0] b1;
  } vec_t;

  vec_t vecs[$];

  int n_cmp = 0;
  int n_err = 0;

  // Observed stream state, updated once per cycle on the falling edge.
  logic [7:0] cap [NL][NB];
  int cyc = 0, lines = 0, bidx = 0;
  int vs_rise_cyc = 0, vs_fall_cyc = 0, vs_width = 0, first_href_cyc = 0;
  int href_fall_cyc = 0, fd_cyc = 0, fd_prev = 0;
  int overlap_err = 0, idle_data_err = 0, hw_err = 0, hb_err = 0;
  logic vs_prev = 1'b0, href_prev = 1'b0;

  function automatic void add_vec(int f, int x, int y, logic [7:0] b0, logic [7:0] b1);
    vec_t v;
    v.frame = f; v.x = x; v.y = y; v.b0 = b0; v.b1 = b1;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic finish_up();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  endtask

  task automatic sample();
    cyc++;
    if (CAM_VSYNC && CAM_HREF) overlap_err++;
    if (!CAM_HREF && CAM_px_data != 8'h00) idle_data_err++;
    if (rst) begin
      vs_prev = 1'b0; href_prev = 1'b0; lines = 0; bidx = 0;
    end else begin
      if (CAM_VSYNC && !vs_prev) begin
        vs_rise_cyc = cyc; lines = 0;
      end
      if (!CAM_VSYNC && vs_prev) begin
        vs_fall_cyc = cyc; vs_width = cyc - vs_rise_cyc;
      end
      if (CAM_HREF && !href_prev) begin
        if (lines == 0) first_href_cyc = cyc;
        else if (cyc - href_fall_cyc != 16) hb_err++;
        lines++;
        bidx = 0;
      end
      if (!CAM_HREF && href_prev) begin
        href_fall_cyc = cyc;
        if (bidx != NB) hw_err++;
      end
      if (CAM_HREF) begin
        if (lines >= 1 && lines <= NL && bidx < NB) cap[lines-1][bidx] = CAM_px_data;
        bidx++;
      end
      if (frame_done) begin
        fd_prev = fd_cyc; fd_cyc = cyc;
      end
      vs_prev = CAM_VSYNC;
      href_prev = CAM_HREF;
    end
  endtask

  task automatic step();
    @(negedge clk);
    sample();
  endtask

  task automatic wait_fd(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < WAIT_MAX; i++) begin
      step();
      if (frame_done) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, int'(ok), 1);
  endtask

  task automatic wait_pos(input string name, input int ln, input int bx, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < WAIT_MAX; i++) begin
      step();
      if (lines == ln && bidx == bx) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, int'(ok), 1);
  endtask

  task automatic chk_frame_vecs(input int f);
    foreach (vecs[i]) begin
      if (vecs[i].frame == f) begin
        chk($sformatf("frame%0d px(%0d,%0d) byte0", f, vecs[i].x, vecs[i].y),
            int'(cap[vecs[i].y][2*vecs[i].x]), int'(vecs[i].b0));
        chk($sformatf("frame%0d px(%0d,%0d) byte1", f, vecs[i].x, vecs[i].y),
            int'(cap[vecs[i].y][2*vecs[i].x+1]), int'(vecs[i].b1));
      end
    end
  endtask

  task automatic chk_protocol(input string tag);
    chk({tag, " vsync/href overlap"}, overlap_err, 0);
    chk({tag, " data while href low"}, idle_data_err, 0);
    chk({tag, " href width"}, hw_err, 0);
    chk({tag, " hblank width"}, hb_err, 0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, " vsync"}, int'(CAM_VSYNC), 0);
    chk({tag, " href"}, int'(CAM_HREF), 0);
    chk({tag, " px_data"}, int'(CAM_px_data), 0);
    chk({tag, " frame_done"}, int'(frame_done), 0);
  endtask

  initial begin
    bit ok;
    int bad;
    int act_cnt;

    // Frame 0: solid 0xA5C
    add_vec(0,   0,   0, 8'h0A, 8'h5C);
    add_vec(0,  80,  60, 8'h0A, 8'h5C);
    add_vec(0, 159, 119, 8'h0A, 8'h5C);
    // Frame 1: pixel counter (y*160+x) mod 4096
    add_vec(1,   0,   0, 8'h00, 8'h00);
    add_vec(1,   5,   2, 8'h01, 8'h45);
    add_vec(1, 159,   0, 8'h00, 8'h9F);
    add_vec(1,  25,  25, 8'h0F, 8'hB9);
    add_vec(1,  96,  25, 8'h00, 8'h00);
    add_vec(1,   0, 119, 8'h0A, 8'h60);
    add_vec(1, 159, 119, 8'h0A, 8'hFF);
    // Frame 2: colour bars, 20 pixels each
    add_vec(2,   0,   0, 8'h0F, 8'hFF);
    add_vec(2,  19,   0, 8'h0F, 8'hFF);
    add_vec(2,  20,   0, 8'h0F, 8'hF0);
    add_vec(2,  39,   0, 8'h0F, 8'hF0);
    add_vec(2,  40,   0, 8'h00, 8'hFF);
    add_vec(2,  60,   0, 8'h00, 8'hF0);
    add_vec(2,  80,   0, 8'h0F, 8'h0F);
    add_vec(2, 100,   0, 8'h0F, 8'h00);
    add_vec(2, 120,   0, 8'h00, 8'h0F);
    add_vec(2, 140,   0, 8'h00, 8'h00);
    add_vec(2, 159,   0, 8'h00, 8'h00);
    add_vec(2,  20,  49, 8'h0F, 8'hF0);

    repeat (3) step();
    chk_outputs_zero("reset");

    rst = 1'b0; enable = 1'b1; pattern_sel = 2'd0; solid_color = 12'hA5C;
    step();
    chk("vsync on first enabled cycle", int'(CAM_VSYNC), 1);
    repeat (3) step();
    // Changing inputs mid-frame must not disturb the latched pattern.
    pattern_sel = 2'd3; solid_color = 12'h123;

    wait_fd("frame0 frame_done seen", ok);
    if (!ok) finish_up();
    chk("frame0 length", fd_cyc - vs_rise_cyc + 1, FRAME_LEN);
    chk("vsync width", vs_width, 8);
    chk("vsync fall to first href", first_href_cyc - vs_fall_cyc, 10);
    chk("frame0 href pulses", lines, NL);
    chk_protocol("frame0");
    bad = 0;
    for (int y = 0; y < NL; y++)
      for (int b = 0; b < NB; b++)
        if (cap[y][b] != (((b % 2) == 0) ? 8'h0A : 8'h5C)) bad++;
    chk("frame0 solid byte errors", bad, 0);
    chk_frame_vecs(0);

    step();
    chk("frame_done one cycle", int'(frame_done), 0);
    chk("back-to-back vsync", int'(CAM_VSYNC), 1);

    wait_pos("frame1 reached line 60", 61, 100, ok);
    if (!ok) finish_up();
    enable = 1'b0;
    wait_fd("frame1 frame_done seen", ok);
    if (!ok) finish_up();
    chk("frame_done period", fd_cyc - fd_prev, FRAME_LEN);
    chk("frame1 href pulses", lines, NL);
    chk_protocol("frame1");
    chk_frame_vecs(1);

    act_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (CAM_VSYNC || CAM_HREF) act_cnt++;
    end
    chk("idle activity after enable drop", act_cnt, 0);

    pattern_sel = 2'd1; enable = 1'b1;
    wait_pos("frame2 reached line 50", 51, 100, ok);
    if (!ok) finish_up();
    rst = 1'b1;
    step();
    chk_outputs_zero("mid-line reset");
    chk_frame_vecs(2);
    step();
    chk("vsync held in reset", int'(CAM_VSYNC), 0);
    rst = 1'b0;
    step();
    chk("vsync after reset release", int'(CAM_VSYNC), 1);
    chk("href after reset release", int'(CAM_HREF), 0);
    chk_protocol("final");

    finish_up();
  end

endmodule
`default_nettype wire
